// File: rtl/aes_pkg.sv
// aes_pkg
// Shared AES-128 key-schedule definitions used by key_expand_ctrl and key_store.
// Provides the round-count and width constants, the round-key type and the
// controller state encoding.
package aes_pkg;

  localparam int AES_NROUNDS = 10;
  localparam int AES_KEY_W   = 128;
  localparam int AES_RND_W   = 4;
  localparam int AES_NKEYS   = AES_NROUNDS + 1;

  typedef logic [AES_KEY_W-1:0] round_key_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } kec_state_t;

endpackage

// File: rtl/key_store.sv
// key_store
// 11 x 128-bit round-key register file, one synchronous write port and one
// combinational read port. Reads of addresses beyond the last round key
// return zero.
// Ports:
//   clk, reset        clock, asynchronous active-low reset (clears all keys)
//   wr_en/wr_addr/wr_key  write port
//   rd_addr/rd_key    combinational read port
module key_store
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AES_RND_W-1:0] wr_addr,
  input  round_key_t           wr_key,
  input  logic [AES_RND_W-1:0] rd_addr,
  output round_key_t           rd_key
);

  round_key_t mem [AES_NKEYS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < AES_NKEYS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (wr_addr < AES_RND_W'(AES_NKEYS))) begin
      mem[wr_addr] <= wr_key;
    end
  end

  // The 4-bit address space is larger than the key file; unused slots read 0.
  always_comb begin
    rd_key = '0;
    if (rd_addr < AES_RND_W'(AES_NKEYS)) begin
      rd_key = mem[rd_addr];
    end
  end

endmodule

// File: rtl/key_expand_ctrl.sv
// key_expand_ctrl
// Sequences an external keysched block through AES-128 rounds 1..10, one
// start pulse per round, and keeps all 11 round keys in a key_store with a
// random-access read port for the cipher pipeline.
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   key_load_i, key_i       host key-load strobe and cipher key
//   busy_o                  expansion (or drain of an aborted round) in progress
//   keys_valid_o            all 11 round keys valid
//   error_o                 sticky keysched timeout flag, cleared by a new load
//   rd_addr_i/rd_key_o/rd_valid_o  round-key read port with per-key valid
//   ks_start_o, ks_round_o, ks_last_key_o  request to keysched
//   ks_new_key_i, ks_ready_i               result from keysched
module key_expand_ctrl
  import aes_pkg::*;
#(
  parameter int NROUNDS = AES_NROUNDS,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_load_i,
  input  logic [AES_KEY_W-1:0] key_i,
  output logic                 busy_o,
  output logic                 keys_valid_o,
  output logic                 error_o,
  input  logic [AES_RND_W-1:0] rd_addr_i,
  output logic [AES_KEY_W-1:0] rd_key_o,
  output logic                 rd_valid_o,
  output logic                 ks_start_o,
  output logic [AES_RND_W-1:0] ks_round_o,
  output logic [AES_KEY_W-1:0] ks_last_key_o,
  input  logic [AES_KEY_W-1:0] ks_new_key_i,
  input  logic                 ks_ready_i
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  kec_state_t           state, state_next;
  logic [3:0]           keys_done, keys_done_next;
  logic [AES_RND_W-1:0] round_q, round_next;
  round_key_t           last_key_q, last_key_next;
  round_key_t           pending_q, pending_next;
  logic [TMR_W-1:0]     timer_q, timer_next;
  logic                 error_q, error_next;

  logic                 wr_en;
  logic [AES_RND_W-1:0] wr_addr;
  round_key_t           wr_key;
  logic                 do_load;
  round_key_t           load_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      keys_done  <= '0;
      round_q    <= '0;
      last_key_q <= '0;
      pending_q  <= '0;
      timer_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state      <= state_next;
      keys_done  <= keys_done_next;
      round_q    <= round_next;
      last_key_q <= last_key_next;
      pending_q  <= pending_next;
      timer_q    <= timer_next;
      error_q    <= error_next;
    end
  end

  always_comb begin
    state_next     = state;
    keys_done_next = keys_done;
    round_next     = round_q;
    last_key_next  = last_key_q;
    pending_next   = pending_q;
    timer_next     = timer_q;
    error_next     = error_q;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_key         = '0;
    do_load        = 1'b0;
    load_val       = key_i;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (key_load_i) begin
          do_load  = 1'b1;
          load_val = key_i;
        end
      end

      // A load here arrives after the start pulse went out, so the round in
      // flight must still be drained before restarting.
      ST_ISSUE: begin
        timer_next = '0;
        if (key_load_i) begin
          pending_next   = key_i;
          keys_done_next = '0;
          state_next     = ST_DRAIN;
        end else begin
          state_next = ST_WAIT;
        end
      end

      // A load coinciding with the result means keysched is already idle, so
      // the result is dropped and the new key starts at once.
      ST_WAIT: begin
        if (key_load_i && ks_ready_i) begin
          do_load  = 1'b1;
          load_val = key_i;
        end else if (key_load_i) begin
          pending_next   = key_i;
          keys_done_next = '0;
          timer_next     = timer_q + 1'b1;
          state_next     = ST_DRAIN;
        end else if (ks_ready_i) begin
          wr_en          = 1'b1;
          wr_addr        = round_q;
          wr_key         = ks_new_key_i;
          last_key_next  = ks_new_key_i;
          keys_done_next = keys_done + 4'd1;
          if (round_q == AES_RND_W'(NROUNDS)) begin
            state_next = ST_DONE;
          end else begin
            round_next = round_q + 1'b1;
            state_next = ST_ISSUE;
          end
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          error_next = 1'b1;
          state_next = ST_IDLE;
        end else begin
          timer_next = timer_q + 1'b1;
        end
      end

      // The timer keeps running from WAIT so a lost result still times out.
      ST_DRAIN: begin
        if (ks_ready_i) begin
          do_load  = 1'b1;
          load_val = key_load_i ? key_i : pending_q;
        end else begin
          if (key_load_i) begin
            pending_next = key_i;
          end
          if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            error_next = 1'b1;
            state_next = ST_IDLE;
          end else begin
            timer_next = timer_q + 1'b1;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase

    // Common restart: the cipher key becomes round key 0 and round 1 is issued.
    if (do_load) begin
      wr_en          = 1'b1;
      wr_addr        = '0;
      wr_key         = load_val;
      last_key_next  = load_val;
      round_next     = AES_RND_W'(1);
      keys_done_next = 4'd1;
      error_next     = 1'b0;
      state_next     = ST_ISSUE;
    end
  end

  key_store u_key_store (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_key  (wr_key),
    .rd_addr (rd_addr_i),
    .rd_key  (rd_key_o)
  );

  assign busy_o        = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_DRAIN);
  assign ks_start_o    = (state == ST_ISSUE);
  assign ks_round_o    = round_q;
  assign ks_last_key_o = last_key_q;
  assign error_o       = error_q;
  assign rd_valid_o    = (rd_addr_i < keys_done);
  assign keys_valid_o  = (keys_done == 4'(AES_NKEYS));

endmodule

// File: tb/tb_key_expand_ctrl.sv
// tb_key_expand_ctrl
// Self-checking bench for key_expand_ctrl. A behavioural keysched (5-cycle
// latency, AES-128 key expansion computed from GF(2^8) arithmetic) answers
// start pulses; expected round keys come from an independent full expansion.
module tb_key_expand_ctrl;
  import aes_pkg::*;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         key_load_i = 1'b0;
  logic [127:0] key_i = '0;
  logic         busy_o, keys_valid_o, error_o;
  logic [3:0]   rd_addr_i = '0;
  logic [127:0] rd_key_o;
  logic         rd_valid_o;
  logic         ks_start_o;
  logic [3:0]   ks_round_o;
  logic [127:0] ks_last_key_o;
  logic [127:0] ks_new_key_i = '0;
  logic         ks_ready_i = 1'b0;

  int check_count = 0;
  int fail_count  = 0;
  int busy_starts = 0;
  int ks_cnt      = 0;
  logic [127:0] ks_result = '0;
  bit hang = 1'b0;
  bit spur = 1'b0;
  logic [127:0] exp_keys [0:10];

  typedef struct packed {
    logic [3:0]   addr;
    logic [127:0] exp_key;
    logic         exp_valid;
  } rd_vec_t;
  rd_vec_t vecs [6];

  key_expand_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .key_load_i    (key_load_i),
    .key_i         (key_i),
    .busy_o        (busy_o),
    .keys_valid_o  (keys_valid_o),
    .error_o       (error_o),
    .rd_addr_i     (rd_addr_i),
    .rd_key_o      (rd_key_o),
    .rd_valid_o    (rd_valid_o),
    .ks_start_o    (ks_start_o),
    .ks_round_o    (ks_round_o),
    .ks_last_key_o (ks_last_key_o),
    .ks_new_key_i  (ks_new_key_i),
    .ks_ready_i    (ks_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xtime(a);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_round_key(input logic [127:0] k, input int r);
    logic [7:0]  rc;
    logic [31:0] w3, t, n0, n1, n2, n3;
    rc = 8'h01;
    for (int i = 1; i < r; i++) rc = xtime(rc);
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  task automatic computeExpected(input logic [127:0] k);
    exp_keys[0] = k;
    for (int r = 1; r <= 10; r++) exp_keys[r] = next_round_key(exp_keys[r-1], r);
  endtask

  // Behavioural keysched: result presented five cycles after the start pulse.
  always @(negedge clk) begin
    if (!reset) begin
      ks_cnt     = 0;
      ks_ready_i = 1'b0;
    end else begin
      ks_ready_i = 1'b0;
      if (ks_cnt > 0) begin
        ks_cnt--;
        if (ks_cnt == 0) begin
          ks_ready_i   = 1'b1;
          ks_new_key_i = ks_result;
        end
      end else if (spur) begin
        ks_ready_i   = 1'b1;
        ks_new_key_i = {$urandom, $urandom, $urandom, $urandom};
      end
      if (ks_start_o) begin
        if (ks_cnt > 0) busy_starts++;
        if (!hang) begin
          ks_cnt    = 5;
          ks_result = next_round_key(ks_last_key_o, int'(ks_round_o));
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] k);
    @(negedge clk);
    key_load_i = 1'b1;
    key_i      = k;
    @(negedge clk);
    key_load_i = 1'b0;
  endtask

  task automatic readKey(input logic [3:0] a, input logic [127:0] exp_k, input string name);
    rd_addr_i = a;
    #1;
    checkOutput(name, rd_key_o, exp_k);
  endtask

  task automatic readValid(input logic [3:0] a, input logic exp_v, input string name);
    rd_addr_i = a;
    #1;
    checkOutput(name, rd_valid_o, exp_v);
  endtask

  task automatic checkAllKeys(input string tag);
    for (int a = 0; a < 16; a++) begin
      readKey(4'(a), (a <= 10) ? exp_keys[a] : 128'h0, $sformatf("%s_key%0d", tag, a));
      checkOutput($sformatf("%s_valid%0d", tag, a), rd_valid_o, (a <= 10));
    end
  endtask

  task automatic waitValid(output int n);
    n = 0;
    while (!keys_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic spuriousReady();
    @(posedge clk);
    spur = 1'b1;
    @(posedge clk);
    spur = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [127:0] ka, kb, kexp;

    vecs[0] = '{addr: 4'd0,  exp_key: FIPS_KEY, exp_valid: 1'b1};
    vecs[1] = '{addr: 4'd1,  exp_key: FIPS_K1,  exp_valid: 1'b1};
    vecs[2] = '{addr: 4'd10, exp_key: FIPS_K10, exp_valid: 1'b1};
    vecs[3] = '{addr: 4'd11, exp_key: 128'h0,   exp_valid: 1'b0};
    vecs[4] = '{addr: 4'd12, exp_key: 128'h0,   exp_valid: 1'b0};
    vecs[5] = '{addr: 4'd15, exp_key: 128'h0,   exp_valid: 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_keys_valid", keys_valid_o, 0);
    checkOutput("rst_error", error_o, 0);
    checkOutput("rst_start", ks_start_o, 0);
    checkOutput("rst_round", ks_round_o, 0);
    checkOutput("rst_last_key", ks_last_key_o, 0);
    readValid(0, 0, "rst_rd_valid0");
    readKey(0, 0, "rst_rd_key0");
    @(negedge clk);
    reset = 1'b1;

    // FIPS-197 expansion, latency and mid-expansion reads
    computeExpected(FIPS_KEY);
    applyStimulus(FIPS_KEY);
    checkOutput("fips_first_start", ks_start_o, 1);
    checkOutput("fips_first_round", ks_round_o, 1);
    checkOutput("fips_first_last_key", ks_last_key_o, FIPS_KEY);
    checkOutput("fips_busy", busy_o, 1);
    n = 0;
    while (!keys_valid_o && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 20) begin
        readValid(3, 1, "mid_valid3");
        readKey(3, exp_keys[3], "mid_key3");
        readValid(4, 0, "mid_valid4");
        readKey(12, 0, "mid_key12");
        readValid(12, 0, "mid_valid12");
      end
    end
    checkOutput("fips_latency", n, 60);
    for (int i = 0; i < 6; i++) begin
      readKey(vecs[i].addr, vecs[i].exp_key, $sformatf("vec%0d_key", i));
      checkOutput($sformatf("vec%0d_valid", i), rd_valid_o, vecs[i].exp_valid);
    end
    checkOutput("done_busy", busy_o, 0);
    checkOutput("done_round", ks_round_o, 10);
    checkOutput("done_last_key", ks_last_key_o, FIPS_K10);

    // Spurious ready in DONE must not disturb stored keys
    spuriousReady();
    repeat (3) @(negedge clk);
    checkOutput("spur_done_valid", keys_valid_o, 1);
    checkAllKeys("spur_done");

    // Abort with an all-zero key during round-5 WAIT
    applyStimulus(FIPS_KEY);
    repeat (25) @(negedge clk);
    applyStimulus(128'h0);
    checkOutput("abort_keys_valid", keys_valid_o, 0);
    checkOutput("abort_busy", busy_o, 1);
    readValid(0, 0, "abort_valid0");
    readValid(4, 0, "abort_valid4");
    waitValid(n);
    checkOutput("abort_done", keys_valid_o, 1);
    computeExpected(128'h0);
    readKey(10, ZERO_K10, "abort_key10");
    checkAllKeys("abort");

    // Keysched never answers: timeout
    hang = 1'b1;
    ka = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(ka);
    repeat (15) @(negedge clk);
    checkOutput("to_error_early", error_o, 0);
    checkOutput("to_busy_early", busy_o, 1);
    @(negedge clk);
    checkOutput("to_error", error_o, 1);
    checkOutput("to_busy", busy_o, 0);
    checkOutput("to_keys_valid", keys_valid_o, 0);
    readValid(0, 1, "to_valid0");
    readKey(0, ka, "to_key0");
    readValid(1, 0, "to_valid1");
    spuriousReady();
    repeat (2) @(negedge clk);
    readKey(1, exp_keys[1], "spur_idle_key1");
    readValid(1, 0, "spur_idle_valid1");
    checkOutput("spur_idle_error", error_o, 1);
    hang = 1'b0;
    kb = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(kb);
    checkOutput("to_error_cleared", error_o, 0);
    waitValid(n);
    checkOutput("to_recover_latency", n, 60);
    computeExpected(kb);
    checkAllKeys("to_recover");

    // Asynchronous reset at round 7
    applyStimulus(FIPS_KEY);
    repeat (40) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("arst_busy", busy_o, 0);
    checkOutput("arst_keys_valid", keys_valid_o, 0);
    checkOutput("arst_error", error_o, 0);
    checkOutput("arst_start", ks_start_o, 0);
    checkOutput("arst_round", ks_round_o, 0);
    checkOutput("arst_last_key", ks_last_key_o, 0);
    readKey(1, 0, "arst_key1");
    readValid(0, 0, "arst_valid0");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(FIPS_KEY);
    waitValid(n);
    checkOutput("arst_latency", n, 60);
    readKey(10, FIPS_K10, "arst_key10");

    // Back-to-back loads from DONE: the second lands in ISSUE and wins
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    key_load_i = 1'b1;
    key_i      = ka;
    @(negedge clk);
    key_i      = kb;
    checkOutput("b2b_start", ks_start_o, 1);
    checkOutput("b2b_round", ks_round_o, 1);
    @(negedge clk);
    key_load_i = 1'b0;
    checkOutput("b2b_busy", busy_o, 1);
    readValid(0, 0, "b2b_valid0");
    waitValid(n);
    checkOutput("b2b_done", keys_valid_o, 1);
    computeExpected(kb);
    checkAllKeys("b2b");

    // Randomized loads, odd iterations aborted at a random point
    for (int it = 0; it < 6; it++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      kexp = ka;
      applyStimulus(ka);
      checkOutput($sformatf("rnd%0d_round", it), ks_round_o, 1);
      if (it % 2 == 1) begin
        repeat ($urandom_range(1, 58)) @(negedge clk);
        kb = {$urandom, $urandom, $urandom, $urandom};
        kexp = kb;
        applyStimulus(kb);
      end
      waitValid(n);
      if (it % 2 == 0) checkOutput($sformatf("rnd%0d_latency", it), n, 60);
      checkOutput($sformatf("rnd%0d_valid", it), keys_valid_o, 1);
      computeExpected(kexp);
      checkAllKeys($sformatf("rnd%0d", it));
    end

    checkOutput("start_while_busy", busy_starts, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
